// File: rtl/cv4_column_feeder_pkg.sv
// Shared CNN definitions: FP16 element width and the column-feeder FSM states.
package cv4_column_feeder_pkg;

  localparam int unsigned Fp16Width = 16;

  typedef enum logic [1:0] {
    StIdle,
    StLoadK,
    StStream,
    StDrain
  } feeder_state_e;

endpackage

// File: rtl/cv4_column_feeder.sv
// Loads KERNEL_SIZE kernel columns, then streams NUM_COLS feature columns toward the
// channel consumer through a two-stage flag/data alignment pipeline.
module cv4_column_feeder
  import cv4_column_feeder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = Fp16Width,
  parameter int unsigned KERNEL_SIZE          = 4,
  parameter int unsigned INPUT_COL_SIZE       = 5,
  parameter int unsigned INPUT_CHANNEL_NUMBER = 8,
  parameter int unsigned NUM_COLS             = 5
) (
  input  logic                                                          clk,
  input  logic                                                          rst,
  input  logic                                                          start,
  input  logic                                                          stall,
  output logic                                                          busy,
  output logic                                                          done,
  output logic                                                          kern_rd_en,
  output logic [$clog2(KERNEL_SIZE)-1:0]                                kern_rd_addr,
  input  logic [INPUT_CHANNEL_NUMBER-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]    kern_rd_data,
  output logic                                                          fmap_rd_en,
  output logic [$clog2(NUM_COLS)-1:0]                                   fmap_rd_addr,
  input  logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] fmap_rd_data,
  output logic                                                          kernel_load,
  output logic [INPUT_CHANNEL_NUMBER-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]    kernel_inputs,
  output logic                                                          valid_in,
  output logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] input_columns
);

  localparam int unsigned KAW = $clog2(KERNEL_SIZE);
  localparam int unsigned FAW = $clog2(NUM_COLS);

  feeder_state_e  state_q;
  logic [KAW-1:0] kaddr_q;
  logic [FAW-1:0] faddr_q;
  logic           fmap_issue;
  logic           f_last_issue;

  // Stage 1 tracks reads in flight; stage 2 presents the captured column.
  logic k_vld1_q, f_vld1_q, f_last1_q;
  logic kernel_load_q, valid_in_q, done_q;
  logic [INPUT_CHANNEL_NUMBER-1:0][KERNEL_SIZE-1:0][DATA_WIDTH-1:0]    kernel_inputs_q;
  logic [INPUT_CHANNEL_NUMBER-1:0][INPUT_COL_SIZE-1:0][DATA_WIDTH-1:0] input_columns_q;

  assign fmap_issue   = (state_q == StStream) && !stall;
  assign f_last_issue = fmap_issue && (faddr_q == FAW'(NUM_COLS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      kaddr_q <= '0;
      faddr_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLoadK;
            kaddr_q <= '0;
            faddr_q <= '0;
          end
        end
        StLoadK: begin
          if (kaddr_q == KAW'(KERNEL_SIZE - 1)) begin
            state_q <= StStream;
          end else begin
            kaddr_q <= kaddr_q + KAW'(1);
          end
        end
        StStream: begin
          if (f_last_issue) begin
            state_q <= StDrain;
          end else if (fmap_issue) begin
            faddr_q <= faddr_q + FAW'(1);
          end
        end
        StDrain: begin
          if (done_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_vld1_q        <= 1'b0;
      f_vld1_q        <= 1'b0;
      f_last1_q       <= 1'b0;
      kernel_load_q   <= 1'b0;
      valid_in_q      <= 1'b0;
      done_q          <= 1'b0;
      kernel_inputs_q <= '0;
      input_columns_q <= '0;
    end else begin
      k_vld1_q      <= kern_rd_en;
      f_vld1_q      <= fmap_issue;
      f_last1_q     <= f_last_issue;
      kernel_load_q <= k_vld1_q;
      valid_in_q    <= f_vld1_q;
      done_q        <= f_last1_q;
      if (k_vld1_q) kernel_inputs_q <= kern_rd_data;
      if (f_vld1_q) input_columns_q <= fmap_rd_data;
    end
  end

  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign kern_rd_en    = (state_q == StLoadK);
  assign kern_rd_addr  = kaddr_q;
  assign fmap_rd_en    = fmap_issue;
  assign fmap_rd_addr  = faddr_q;
  assign kernel_load   = kernel_load_q;
  assign kernel_inputs = kernel_inputs_q;
  assign valid_in      = valid_in_q;
  assign input_columns = input_columns_q;

endmodule

// File: tb/tb_cv4_column_feeder.sv
// Bench for cv4_column_feeder: memory model plus a cycle-schedule reference derived from
// the job timing rules (kernel 3..6 after start, features 2 cycles after each unstalled issue).
module tb_cv4_column_feeder;

  localparam int DW = 16;
  localparam int K  = 4;
  localparam int L  = 5;
  localparam int C  = 8;
  localparam int N  = 5;
  localparam int H  = 48;

  typedef logic [C-1:0][K-1:0][DW-1:0] kcol_t;
  typedef logic [C-1:0][L-1:0][DW-1:0] fcol_t;

  logic clk, rst, start, stall;
  logic busy, done, kern_rd_en, fmap_rd_en, kernel_load, valid_in;
  logic [$clog2(K)-1:0] kern_rd_addr;
  logic [$clog2(N)-1:0] fmap_rd_addr;
  kcol_t kern_rd_data, kernel_inputs;
  fcol_t fmap_rd_data, input_columns;

  int checks = 0;
  int errors = 0;

  kcol_t kmem [K];
  fcol_t fmem [N];
  kcol_t exp_kin;
  fcol_t exp_fin;

  cv4_column_feeder dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .stall         (stall),
    .busy          (busy),
    .done          (done),
    .kern_rd_en    (kern_rd_en),
    .kern_rd_addr  (kern_rd_addr),
    .kern_rd_data  (kern_rd_data),
    .fmap_rd_en    (fmap_rd_en),
    .fmap_rd_addr  (fmap_rd_addr),
    .fmap_rd_data  (fmap_rd_data),
    .kernel_load   (kernel_load),
    .kernel_inputs (kernel_inputs),
    .valid_in      (valid_in),
    .input_columns (input_columns)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic kcol_t rand_k();
    kcol_t v;
    for (int c = 0; c < C; c++)
      for (int e = 0; e < K; e++) v[c][e] = DW'($urandom);
    return v;
  endfunction

  function automatic fcol_t rand_f();
    fcol_t v;
    for (int c = 0; c < C; c++)
      for (int e = 0; e < L; e++) v[c][e] = DW'($urandom);
    return v;
  endfunction

  // Synchronous read memories; garbage on the bus when not reading.
  always @(posedge clk) begin
    kern_rd_data <= kern_rd_en ? kmem[kern_rd_addr] : rand_k();
    fmap_rd_data <= fmap_rd_en ? fmem[fmap_rd_addr] : rand_f();
  end

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic fill_mem(input bit pattern);
    for (int a = 0; a < K; a++)
      for (int c = 0; c < C; c++)
        for (int e = 0; e < K; e++)
          kmem[a][c][e] = pattern ? DW'(32'h3C00 + a + c * 16 + e * 256) : DW'($urandom);
    for (int a = 0; a < N; a++)
      for (int c = 0; c < C; c++)
        for (int e = 0; e < L; e++)
          fmem[a][c][e] = pattern ? DW'(32'h4400 + a + c * 16 + e * 256) : DW'($urandom);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", 1024'(busy), 1024'(0));
      chk("idle_flags", 1024'({kernel_load, valid_in, done, kern_rd_en}), 1024'(0));
      chk("idle_kin", 1024'(kernel_inputs), 1024'(exp_kin));
      chk("idle_fin", 1024'(input_columns), 1024'(exp_fin));
      start = 1'b0;
      stall = 1'($urandom_range(0, 1));
    end
  endtask

  // stall_mode: 0 none, 1 stall in cycles 6-7, 2 random. rst_at < 0 means no reset.
  task automatic run_job(input bit hold, input int stall_mode, input int rst_at, input bit pattern);
    int kl_idx [H];
    int vi_idx [H];
    bit stl    [H];
    int col, done_k, end_k;
    fill_mem(pattern);
    for (int k = 0; k < H; k++) begin
      kl_idx[k] = -1;
      vi_idx[k] = -1;
      case (stall_mode)
        1:       stl[k] = (k == 6 || k == 7);
        2:       stl[k] = (k < 30) && ($urandom_range(0, 2) == 0);
        default: stl[k] = 1'b0;
      endcase
    end
    for (int k = 3; k < 3 + K; k++) kl_idx[k] = k - 3;
    col    = 0;
    done_k = 0;
    for (int k = 5; k < H - 2 && col < N; k++) begin
      if (!stl[k]) begin
        vi_idx[k + 2] = col;
        col++;
        if (col == N) done_k = k + 2;
      end
    end
    if (rst_at >= 0) begin
      for (int k = rst_at + 1; k < H; k++) begin
        kl_idx[k] = -1;
        vi_idx[k] = -1;
      end
      end_k = rst_at + 4;
    end else begin
      end_k = done_k;
    end
    if (done_k == 0) begin
      checks++;
      errors++;
      $display("FAIL sched_bound got no done within %0d want done", H);
      end_k = H - 1;
    end
    for (int k = 0; k <= end_k; k++) begin
      bit exp_busy, exp_done;
      @(negedge clk);
      if (rst_at >= 0 && k == rst_at + 1) begin
        exp_kin = '0;
        exp_fin = '0;
      end
      if (kl_idx[k] >= 0) exp_kin = kmem[kl_idx[k]];
      if (vi_idx[k] >= 0) exp_fin = fmem[vi_idx[k]];
      exp_busy = (k >= 1) && (k <= done_k) && (rst_at < 0 || k <= rst_at);
      exp_done = (k == done_k) && (rst_at < 0 || k <= rst_at);
      chk("busy", 1024'(busy), 1024'(exp_busy));
      chk("done", 1024'(done), 1024'(exp_done));
      chk("kernel_load", 1024'(kernel_load), 1024'(kl_idx[k] >= 0));
      chk("valid_in", 1024'(valid_in), 1024'(vi_idx[k] >= 0));
      chk("kernel_inputs", 1024'(kernel_inputs), 1024'(exp_kin));
      chk("input_columns", 1024'(input_columns), 1024'(exp_fin));
      if (rst_at >= 0 && k > rst_at)
        chk("rst_rd", 1024'({kern_rd_en, kern_rd_addr, fmap_rd_addr}), 1024'(0));
      start = hold || (k == 0);
      stall = stl[k];
      rst   = (k == rst_at);
    end
    rst = 1'b0;
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    stall   = 1'b0;
    exp_kin = '0;
    exp_fin = '0;
    fill_mem(1'b1);
    repeat (3) @(negedge clk);
    chk("rst_state", 1024'({busy, done, kern_rd_en, fmap_rd_en, kernel_load, valid_in}),
        1024'(0));
    chk("rst_addr", 1024'({kern_rd_addr, fmap_rd_addr}), 1024'(0));
    chk("rst_kin", 1024'(kernel_inputs), 1024'(0));
    chk("rst_fin", 1024'(input_columns), 1024'(0));
    rst = 1'b0;
    idle_check(2);

    run_job(1'b0, 0, -1, 1'b1);
    idle_check(3);
    run_job(1'b0, 1, -1, 1'b0);
    idle_check(3);
    run_job(1'b1, 0, -1, 1'b0);
    run_job(1'b1, 0, -1, 1'b0);
    idle_check(3);
    run_job(1'b0, 0, 8, 1'b0);
    idle_check(2);
    run_job(1'b0, 0, -1, 1'b1);
    idle_check(2);
    for (int j = 0; j < 4; j++) begin
      run_job(1'($urandom_range(0, 1)), 2, -1, 1'b0);
      idle_check(2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cv4_column_feeder.md
CV4_COLUMN_FEEDER -- requirements
Module: cv4_column_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the FP16 element width.
REQ-002 The block SHALL have parameter KERNEL_SIZE, default 4, giving the kernel columns per channel and the elements per kernel column.
REQ-003 The block SHALL have parameter INPUT_COL_SIZE, default 5, giving the elements per feature column.
REQ-004 The block SHALL have parameter INPUT_CHANNEL_NUMBER, default 8, giving the parallel channels.
REQ-005 The block SHALL have parameter NUM_COLS, default 5, giving the feature columns streamed per job.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 The block SHALL have port start, input, 1 bit: job request, sampled in IDLE.
REQ-009 The block SHALL have port stall, input, 1 bit: blocks feature-read issue in the same cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: job in progress.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle end-of-job pulse.
REQ-012 The block SHALL have port kern_rd_en, output, 1 bit; and port kern_rd_addr, output, $clog2(KERNEL_SIZE) bits: kernel memory read request.
REQ-013 The block SHALL have port kern_rd_data, input, [INPUT_CHANNEL_NUMBER][KERNEL_SIZE] x DATA_WIDTH: kernel column, valid 1 cycle after the request.
REQ-014 The block SHALL have port fmap_rd_en, output, 1 bit; and port fmap_rd_addr, output, $clog2(NUM_COLS) bits: feature memory read request.
REQ-015 The block SHALL have port fmap_rd_data, input, [INPUT_CHANNEL_NUMBER][INPUT_COL_SIZE] x DATA_WIDTH: feature column, valid 1 cycle after the request.
REQ-016 The block SHALL have port kernel_load, output, 1 bit: kernel_inputs valid toward the channel consumer.
REQ-017 The block SHALL have port kernel_inputs, output, [INPUT_CHANNEL_NUMBER][KERNEL_SIZE] x DATA_WIDTH: registered kernel column.
REQ-018 The block SHALL have port valid_in, output, 1 bit: input_columns valid toward the channel consumer.
REQ-019 The block SHALL have port input_columns, output, [INPUT_CHANNEL_NUMBER][INPUT_COL_SIZE] x DATA_WIDTH: registered feature column.

Function
REQ-020 The FSM SHALL have the states IDLE, LOAD_K, STREAM, DRAIN.
- IDLE with start=1 goes to LOAD_K.
- LOAD_K goes to STREAM after issuing kernel address KERNEL_SIZE-1.
- STREAM goes to DRAIN after issuing feature address NUM_COLS-1.
- DRAIN goes to IDLE once the final output has been emitted.
REQ-021 In LOAD_K the block SHALL issue kern_rd_en with addresses 0..KERNEL_SIZE-1 on consecutive cycles; stall SHALL be ignored in LOAD_K.
REQ-022 In STREAM the block SHALL issue fmap_rd_en with addresses 0..NUM_COLS-1 in order; a cycle with stall=1 SHALL issue nothing and hold the address.
REQ-023 Each read SHALL be returned on the read-data port 1 cycle after it is issued, captured into the output register, and presented 2 cycles after issue with kernel_load or valid_in high for exactly 1 cycle.
REQ-024 kernel_load and valid_in SHALL never be high in the same cycle, and the block SHALL never present a column without its flag high.
REQ-025 The first valid_in SHALL NOT precede the last kernel_load; with no stall, valid_in SHALL directly follow kernel_load.
REQ-026 Output data registers SHALL hold their value when their flag is low.
REQ-027 busy SHALL be high from the cycle after start is accepted through the done cycle inclusive.
REQ-028 done SHALL pulse coincident with the last valid_in of the job.
REQ-029 start while busy SHALL be ignored.
REQ-030 start in the same cycle as done SHALL be ignored; a new job is accepted only in IDLE.
REQ-031 Address counters SHALL reset to 0 at each job start and SHALL NOT wrap mid-job.

Reset
REQ-032 When rst=1 at a clock edge, the state SHALL become IDLE and all outputs SHALL be 0: busy, done, kern_rd_en, fmap_rd_en, addresses, kernel_load, valid_in, kernel_inputs, input_columns.
REQ-033 Reset mid-job SHALL abort the job: no further kernel_load, valid_in or done for that job, and in-flight reads are discarded.

Structure
REQ-034 The state enum and the FP16 width constant SHALL live in the shared CNN package; array-size parameters stay module parameters.
REQ-035 The block SHALL be a single module with no sub-module, since the read-alignment pipeline is two flag/data register stages.

Verification
REQ-036 Defaults, start pulsed at cycle 0, no stall -> kernel_load high cycles 3-6 with kernel addresses 0-3 in order, valid_in high cycles 7-11 with feature columns 0-4, done at cycle 11, busy high cycles 1-11.
REQ-037 stall=1 for cycles 6-7 -> feature reads for columns 0-1 are held; valid_in has a 2-cycle gap, columns stay in order, done moves to cycle 13.
REQ-038 start held high continuously for two jobs -> the second job starts in IDLE after done, not during the first job; exactly 4 kernel_load and 5 valid_in per job.
REQ-039 rst asserted at cycle 8 of a job -> all outputs are 0 at cycle 9, no done; a new start afterward runs a clean full job.
REQ-040 Memory returns distinct patterns per channel/address (e.g. 16'h3C00 + addr) -> kernel_inputs and input_columns match bit-exactly per channel.
